// File: rtl/sample_sender_pkg.sv
// Shared definitions for the capture-buffer readback path:
// default sample width, bytes-per-sample helper and the serializer state encoding.
package sample_sender_pkg;

   localparam int SAMPLE_WIDTH = 8;

   function automatic int bytes_per_sample(input int width);
      return (width + 7) / 8;
   endfunction

   localparam int BYTES_PER_SAMPLE = bytes_per_sample(SAMPLE_WIDTH);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_LATCH     = 3'd2,
      ST_SEND      = 3'd3,
      ST_WAIT_ACK  = 3'd4,
      ST_WAIT_DONE = 3'd5,
      ST_FINISH    = 3'd6
   } ss_state_e;

endpackage

// File: rtl/sample_sender_addr_down_counter.sv
// Read-address and remaining-sample bookkeeping for sample_sender: loads the newest
// address and a clamped sample count, then steps backwards with modulo-depth wrap.
module addr_down_counter #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_load,
   input  logic [ADDR_WIDTH-1:0] i_last_addr,
   input  logic [ADDR_WIDTH:0]   i_read_count,
   input  logic                  i_step,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_load_zero,
   output logic                  o_rem_is_one
);

   localparam logic [ADDR_WIDTH:0] LP_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH:0]   r_remaining;
   logic [ADDR_WIDTH:0]   w_clamped;

   // A count larger than the buffer can only ever read each sample once.
   always_comb begin
      w_clamped = i_read_count;
      if (i_read_count > LP_DEPTH) begin
         w_clamped = LP_DEPTH;
      end else begin
         w_clamped = i_read_count;
      end
   end

   // Address/count registers; plain subtraction wraps address 0 to the top of the RAM.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_addr      <= {ADDR_WIDTH{1'b0}};
         r_remaining <= {(ADDR_WIDTH+1){1'b0}};
      end else if (i_load) begin
         r_addr      <= i_last_addr;
         r_remaining <= w_clamped;
      end else if (i_step) begin
         r_addr      <= r_addr - ADDR_WIDTH'(1);
         r_remaining <= r_remaining - (ADDR_WIDTH+1)'(1);
      end
   end

   assign o_addr       = r_addr;
   assign o_load_zero  = (i_read_count == {(ADDR_WIDTH+1){1'b0}});
   assign o_rem_is_one = (r_remaining == (ADDR_WIDTH+1)'(1));

endmodule

// File: rtl/sample_sender.sv
// Capture-buffer readback: walks sample RAM from the newest sample backwards and
// hands each sample to the UART transmitter LSB byte first.
module sample_sender #(
   parameter int SAMPLE_WIDTH = sample_sender_pkg::SAMPLE_WIDTH,
   parameter int ADDR_WIDTH   = 10
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   input  logic [ADDR_WIDTH-1:0]   last_addr,
   input  logic [ADDR_WIDTH:0]     read_count,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic [SAMPLE_WIDTH-1:0] mem_data,
   output logic [7:0]              tx_byte,
   output logic                    tx_start,
   input  logic                    tx_busy,
   output logic                    busy,
   output logic                    done
);

   import sample_sender_pkg::*;

   localparam int         LP_NBYTES    = bytes_per_sample(SAMPLE_WIDTH);
   localparam int         LP_SREG_W    = LP_NBYTES * 8;
   localparam logic [3:0] LP_LAST_BYTE = 4'(LP_NBYTES - 1);

   ss_state_e             r_state;
   ss_state_e             w_next_state;
   logic [LP_SREG_W-1:0]  r_sample;
   logic [LP_SREG_W-1:0]  w_sample_shift;
   logic [3:0]            r_byte_idx;
   logic [7:0]            r_tx_byte;
   logic                  r_tx_start;
   logic                  r_busy;
   logic                  r_done;
   logic                  w_load;
   logic                  w_step;
   logic                  w_send;
   logic                  w_next_byte;
   logic                  w_load_zero;
   logic                  w_rem_is_one;
   logic [ADDR_WIDTH-1:0] w_addr;

   addr_down_counter #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_counter (
      .i_clock      (clock),
      .i_reset      (reset),
      .i_load       (w_load),
      .i_last_addr  (last_addr),
      .i_read_count (read_count),
      .i_step       (w_step),
      .o_addr       (w_addr),
      .o_load_zero  (w_load_zero),
      .o_rem_is_one (w_rem_is_one)
   );

   // Zero padding above SAMPLE_WIDTH comes for free from the widened sample register.
   assign w_sample_shift = r_sample >> {r_byte_idx, 3'b000};

   // Next-state logic; abort preempts everything except the idle and finishing states.
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_step       = 1'b0;
      w_send       = 1'b0;
      w_next_byte  = 1'b0;
      if (abort && (r_state != ST_IDLE) && (r_state != ST_FINISH)) begin
         w_next_state = ST_FINISH;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start && !abort) begin
                  w_load       = 1'b1;
                  w_next_state = w_load_zero ? ST_FINISH : ST_ADDR;
               end else begin
                  w_next_state = ST_IDLE;
               end
            end
            ST_ADDR:  w_next_state = ST_LATCH;
            ST_LATCH: w_next_state = ST_SEND;
            ST_SEND: begin
               if (!tx_busy) begin
                  w_send       = 1'b1;
                  w_next_state = ST_WAIT_ACK;
               end else begin
                  w_next_state = ST_SEND;
               end
            end
            ST_WAIT_ACK: begin
               if (tx_busy) begin
                  w_next_state = ST_WAIT_DONE;
               end else begin
                  w_next_state = ST_WAIT_ACK;
               end
            end
            ST_WAIT_DONE: begin
               if (!tx_busy) begin
                  if (r_byte_idx < LP_LAST_BYTE) begin
                     w_next_byte  = 1'b1;
                     w_next_state = ST_SEND;
                  end else begin
                     w_step       = 1'b1;
                     w_next_state = w_rem_is_one ? ST_FINISH : ST_ADDR;
                  end
               end else begin
                  w_next_state = ST_WAIT_DONE;
               end
            end
            ST_FINISH: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
         endcase
      end
   end

   // State, sample capture and registered UART/handshake outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_sample   <= {LP_SREG_W{1'b0}};
         r_byte_idx <= 4'd0;
         r_tx_byte  <= 8'd0;
         r_tx_start <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_tx_start <= w_send;
         r_busy     <= (w_next_state != ST_IDLE) && (w_next_state != ST_FINISH);
         r_done     <= (r_state == ST_FINISH);
         if (w_send) begin
            r_tx_byte <= w_sample_shift[7:0];
         end
         if (r_state == ST_LATCH) begin
            r_sample   <= LP_SREG_W'(mem_data);
            r_byte_idx <= 4'd0;
         end else if (w_next_byte) begin
            r_byte_idx <= r_byte_idx + 4'd1;
         end
      end
   end

   assign mem_addr = w_addr;
   assign tx_byte  = r_tx_byte;
   assign tx_start = r_tx_start;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_sample_sender.sv
// Directed, scoreboard-based bench for sample_sender (8-bit and 12-bit sample instances).
module tb_sample_sender;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start_a = 1'b0;
   logic        start_b = 1'b0;
   logic        abort = 1'b0;
   logic [9:0]  last_addr = 10'd0;
   logic [10:0] read_count = 11'd0;

   logic [9:0]  mem_addr_a, mem_addr_b;
   logic [7:0]  mem_data_a;
   logic [11:0] mem_data_b;
   logic [7:0]  tx_byte_a, tx_byte_b;
   logic        tx_start_a, tx_start_b, tx_busy_a, tx_busy_b;
   logic        busy_a, busy_b, done_a, done_b;

   logic [7:0]  ram_a [0:1023];
   logic [11:0] ram_b [0:1023];
   int          u_a = 0;
   int          u_b = 0;
   int          uart_delay = 0;

   int          checks = 0;
   int          errors = 0;
   int          tx_cnt_a = 0;
   int          tx_cnt_b = 0;
   int          done_cnt_a = 0;
   int          done_cnt_b = 0;
   logic [7:0]  exp_a [$];
   logic [7:0]  exp_b [$];

   always #5 clock = ~clock;

   sample_sender #(.SAMPLE_WIDTH(8), .ADDR_WIDTH(10)) dut_a (
      .clock(clock), .reset(reset), .start(start_a), .abort(abort),
      .last_addr(last_addr), .read_count(read_count), .mem_addr(mem_addr_a),
      .mem_data(mem_data_a), .tx_byte(tx_byte_a), .tx_start(tx_start_a),
      .tx_busy(tx_busy_a), .busy(busy_a), .done(done_a)
   );

   sample_sender #(.SAMPLE_WIDTH(12), .ADDR_WIDTH(10)) dut_b (
      .clock(clock), .reset(reset), .start(start_b), .abort(abort),
      .last_addr(last_addr), .read_count(read_count), .mem_addr(mem_addr_b),
      .mem_data(mem_data_b), .tx_byte(tx_byte_b), .tx_start(tx_start_b),
      .tx_busy(tx_busy_b), .busy(busy_b), .done(done_b)
   );

   // UART busy window: optional delay, then 10 busy cycles
   assign tx_busy_a = (u_a != 0) && (u_a <= 10);
   assign tx_busy_b = (u_b != 0) && (u_b <= 10);

   always @(posedge clock) begin
      mem_data_a <= ram_a[mem_addr_a];
      mem_data_b <= ram_b[mem_addr_b];
      if (tx_start_a) u_a <= 10 + uart_delay;
      else if (u_a != 0) u_a <= u_a - 1;
      if (tx_start_b) u_b <= 10 + uart_delay;
      else if (u_b != 0) u_b <= u_b - 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Scoreboard: every transmit request pops the next expected byte
   always @(negedge clock) begin
      if (tx_start_a === 1'b1) begin
         tx_cnt_a++;
         if (exp_a.size() == 0) check("tx_a_unexpected", 32'(tx_byte_a), 32'hFFFF_FFFF);
         else check("tx_a_byte", 32'(tx_byte_a), 32'(exp_a.pop_front()));
      end
      if (tx_start_b === 1'b1) begin
         tx_cnt_b++;
         if (exp_b.size() == 0) check("tx_b_unexpected", 32'(tx_byte_b), 32'hFFFF_FFFF);
         else check("tx_b_byte", 32'(tx_byte_b), 32'(exp_b.pop_front()));
      end
      if (done_a === 1'b1) done_cnt_a++;
      if (done_b === 1'b1) done_cnt_b++;
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic pulse_start_a();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
   endtask

   task automatic clear_counts();
      tx_cnt_a = 0;
      tx_cnt_b = 0;
      done_cnt_a = 0;
      done_cnt_b = 0;
   endtask

   task automatic wait_tx_a(input int target, input int budget);
      int n = 0;
      while (tx_cnt_a < target && n < budget) begin
         tick();
         n++;
      end
      check("wait_tx_a", tx_cnt_a, target);
   endtask

   task automatic wait_done(input bit use_b, input int budget);
      int n = 0;
      while ((use_b ? done_cnt_b : done_cnt_a) < 1 && n < budget) begin
         tick();
         n++;
      end
      check(use_b ? "wait_done_b" : "wait_done_a", use_b ? done_cnt_b : done_cnt_a, 1);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         ram_a[i] = 8'(i * 7 + 3);
         ram_b[i] = 12'(i * 5 + 1);
      end

      // Reset state
      tick();
      tick();
      check("rst_mem_addr", 32'(mem_addr_a), 32'd0);
      check("rst_tx_byte", 32'(tx_byte_a), 32'd0);
      check("rst_tx_start", 32'(tx_start_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      reset = 1'b0;
      tick();

      // Basic readback, newest first
      ram_a[5] = 8'hA5; ram_a[4] = 8'h3C; ram_a[3] = 8'h0F;
      exp_a.push_back(8'hA5); exp_a.push_back(8'h3C); exp_a.push_back(8'h0F);
      clear_counts();
      last_addr = 10'd5; read_count = 11'd3;
      pulse_start_a();
      check("t1_busy_high", 32'(busy_a), 32'd1);
      wait_done(1'b0, 500);
      tick();
      check("t1_tx_count", tx_cnt_a, 3);
      check("t1_done_count", done_cnt_a, 1);
      check("t1_busy_low", 32'(busy_a), 32'd0);
      check("t1_queue_empty", exp_a.size(), 0);

      // Wrap-around through address 0, UART acknowledging late
      uart_delay = 2;
      ram_a[1] = 8'h11; ram_a[0] = 8'h22; ram_a[1023] = 8'h33; ram_a[1022] = 8'h44;
      exp_a.push_back(8'h11); exp_a.push_back(8'h22); exp_a.push_back(8'h33); exp_a.push_back(8'h44);
      clear_counts();
      last_addr = 10'd1; read_count = 11'd4;
      pulse_start_a();
      wait_done(1'b0, 500);
      tick();
      check("t2_tx_count", tx_cnt_a, 4);
      check("t2_queue_empty", exp_a.size(), 0);
      uart_delay = 0;

      // Zero count: done two cycles after start, nothing sent
      clear_counts();
      read_count = 11'd0;
      pulse_start_a();
      check("t3_done_early", 32'(done_a), 32'd0);
      check("t3_busy", 32'(busy_a), 32'd0);
      tick();
      check("t3_done_2cyc", 32'(done_a), 32'd1);
      tick();
      check("t3_done_single", 32'(done_a), 32'd0);
      check("t3_tx_count", tx_cnt_a, 0);

      // Oversize count clamps to the RAM depth
      clear_counts();
      last_addr = 10'd3; read_count = 11'd2000;
      for (int k = 0; k < 1024; k++) exp_a.push_back(ram_a[(3 - k) & 1023]);
      pulse_start_a();
      wait_done(1'b0, 25000);
      tick();
      check("t4_tx_count", tx_cnt_a, 1024);
      check("t4_queue_empty", exp_a.size(), 0);

      // Multi-byte sample, LSB byte first with zero padding
      clear_counts();
      ram_b[7] = 12'hABC;
      exp_b.push_back(8'hBC); exp_b.push_back(8'h0A);
      last_addr = 10'd7; read_count = 11'd1;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      wait_done(1'b1, 500);
      tick();
      check("t5_tx_count_b", tx_cnt_b, 2);
      check("t5_queue_empty_b", exp_b.size(), 0);

      // Ignored second start, then abort after the third byte
      clear_counts();
      last_addr = 10'd20; read_count = 11'd10;
      exp_a.push_back(ram_a[20]); exp_a.push_back(ram_a[19]); exp_a.push_back(ram_a[18]);
      pulse_start_a();
      wait_tx_a(2, 500);
      last_addr = 10'd100;
      pulse_start_a();
      wait_tx_a(3, 500);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t6_busy_drop", 32'(busy_a), 32'd0);
      tick();
      check("t6_done_pulse", 32'(done_a), 32'd1);
      for (int k = 0; k < 40; k++) tick();
      check("t6_tx_count", tx_cnt_a, 3);
      check("t6_done_count", done_cnt_a, 1);
      check("t6_queue_empty", exp_a.size(), 0);

      // Asynchronous reset while waiting for the UART to finish
      clear_counts();
      last_addr = 10'd50; read_count = 11'd5;
      exp_a.push_back(ram_a[50]);
      pulse_start_a();
      wait_tx_a(1, 500);
      for (int k = 0; k < 4; k++) tick();
      reset = 1'b1;
      #1;
      check("t7_rst_mem_addr", 32'(mem_addr_a), 32'd0);
      check("t7_rst_tx_byte", 32'(tx_byte_a), 32'd0);
      check("t7_rst_tx_start", 32'(tx_start_a), 32'd0);
      check("t7_rst_busy", 32'(busy_a), 32'd0);
      check("t7_rst_done", 32'(done_a), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      check("t7_tx_count", tx_cnt_a, 1);
      check("t7_queue_empty", exp_a.size(), 0);

      // Fresh run after reset uses the new last_addr
      clear_counts();
      last_addr = 10'd60; read_count = 11'd2;
      exp_a.push_back(ram_a[60]); exp_a.push_back(ram_a[59]);
      pulse_start_a();
      wait_done(1'b0, 500);
      tick();
      check("t8_tx_count", tx_cnt_a, 2);
      check("t8_queue_empty", exp_a.size(), 0);
      check("t8_busy_low", 32'(busy_a), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sample_sender.md
Name: sample_sender

Overview:
- Read side of the capture buffer.
- After a capture completes, walks the sample RAM backwards from the most recent sample and streams each sample to the UART transmitter as bytes.
- Sits between the sample memory read port and the UART transmit mux; it is the data-path counterpart of metadata_sender.
- The controller starts it once run drops and selects it with data_meta_mux.

Parameters:
- SAMPLE_WIDTH, 8, bits per captured sample.
- ADDR_WIDTH, 10, sample RAM address width; depth = 2**ADDR_WIDTH.
- BYTES_PER_SAMPLE, (SAMPLE_WIDTH+7)/8, derived constant; bytes transmitted per sample.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begin readback
- abort  in  1  synchronous; cancel readback
- last_addr  in  ADDR_WIDTH  address of the most recently written sample
- read_count  in  ADDR_WIDTH+1  number of samples to send
- mem_addr  out  ADDR_WIDTH  RAM read address; synchronous RAM, 1-cycle read latency
- mem_data  in  SAMPLE_WIDTH  RAM read data
- tx_byte  out  8  byte presented to UART data_out
- tx_start  out  1  single-cycle transmit request (drives trans_en)
- tx_busy  in  1  UART transmitter busy
- busy  out  1  readback in progress
- done  out  1  single-cycle pulse when readback finishes or is aborted

Behaviour:
- Reset values: mem_addr=0, tx_byte=0, tx_start=0, busy=0, done=0. State is IDLE and all counters are 0.
- States: IDLE, ADDR, LATCH, SEND, WAIT_ACK, WAIT_DONE, FINISH.
- IDLE:
  - On start, latch addr=last_addr.
  - Latch remaining=min(read_count, 2**ADDR_WIDTH).
  - If remaining==0, go to FINISH. Otherwise go to ADDR.
  - busy=1 in every state other than IDLE.
- ADDR: drive mem_addr=addr, go to LATCH.
- LATCH:
  - Capture mem_data into sample_reg (RAM data is valid this cycle).
  - Set byte_idx=0, go to SEND.
- SEND:
  - Wait until tx_busy==0.
  - Then, for one cycle, set tx_byte = sample_reg[8*byte_idx +: 8] and tx_start=1, and go to WAIT_ACK.
  - Bits of the top byte above SAMPLE_WIDTH are zero-padded.
  - tx_byte holds its value until the next SEND.
- WAIT_ACK: wait for tx_busy==1, then go to WAIT_DONE. This tolerates a UART that raises busy one or more cycles after trans_en.
- WAIT_DONE: wait for tx_busy==0.
  - If byte_idx < BYTES_PER_SAMPLE-1: increment byte_idx, go to SEND.
  - Else decrement remaining and set addr=addr-1, wrapping modulo 2**ADDR_WIDTH (0 -> 2**ADDR_WIDTH-1).
  - Then if remaining==0 go to FINISH, else go to ADDR.
- FINISH: done=1 for one cycle, busy=0, return to IDLE.
- Ordering: newest sample first, then older samples; bytes within a sample go out LSB first.
- start while busy=1 is ignored.
- abort is highest priority and is honoured in any non-IDLE state.
  - The next cycle goes to FINISH; tx_start is never asserted in that cycle.
  - A byte already handed to the UART completes on its own.
- start and abort in the same cycle while in IDLE: abort wins; no transfer and no done pulse.
- Asynchronous reset mid-transfer forces IDLE with the reset values listed above.
- Throughput: no bubble beyond the states listed.
  - ADDR and LATCH cost 2 cycles per sample.
  - SEND costs 1 cycle when the UART is idle.

Decomposition:
- Shared analyzer package holds:
  - the sample_sender state enum (typedef enum logic [2:0]);
  - SAMPLE_WIDTH;
  - BYTES_PER_SAMPLE, computed by a function.
- One natural sub-module: addr_down_counter, holding the wrapping address decrement and the remaining-count logic.
- The serializer FSM stays in sample_sender.

Test Plan:
- Basic readback: RAM[5]=0xA5, RAM[4]=0x3C, RAM[3]=0x0F; last_addr=5, read_count=3; UART model raises busy 1 cycle after tx_start and holds it 10 cycles.
  - Expected: tx_byte sequence 0xA5, 0x3C, 0x0F; exactly 3 tx_start pulses; then one done pulse; busy low afterwards.
- Wrap-around: last_addr=1, read_count=4, RAM[1]=0x11, RAM[0]=0x22, RAM[1023]=0x33, RAM[1022]=0x44.
  - Expected: bytes 0x11, 0x22, 0x33, 0x44.
- Zero and oversize counts:
  - read_count=0 -> done exactly 2 cycles after start, no tx_start.
  - read_count=2000 -> exactly 1024 bytes sent.
- Multi-byte samples: SAMPLE_WIDTH=12, RAM[7]=0xABC, last_addr=7, read_count=1.
  - Expected: bytes 0xBC then 0x0A.
- Abort and busy-start: start a read_count=10 run.
  - A second start after 2 bytes is ignored.
  - abort after the 3rd tx_start -> no further tx_start; done pulses once; busy=0 within 2 cycles.
- Reset mid-run: assert reset during WAIT_DONE.
  - Expected: outputs return to their reset values while reset is asserted, without waiting for a clock edge.
  - A fresh start after reset sends from the new last_addr.
